// File: rtl/vga_pkg.sv
// Shared timing defaults, frame-buffer geometry, colour field layout and helpers for the VGA sink.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned COLOUR_W  = 6;

  // Colour word is {R[1:0], G[1:0], B[1:0]}.
  localparam int unsigned R_LSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_LSB = 0;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [COLOUR_W-1:0]  colour_t;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic vis;
  } sync_t;

  localparam sync_t SyncIdle = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {4{c}};
  endfunction

  // y*320 + x without a multiplier.
  function automatic fb_addr_t fb_addr(input logic [8:0] x, input logic [7:0] y);
    return (fb_addr_t'(y) << 8) + (fb_addr_t'(y) << 6) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/vga_display_if.sv
// Pixel-write bus from the game datapath into the display's frame buffer.
interface vga_display_if;
  import vga_pkg::*;

  logic [8:0] x_position;
  logic [7:0] y_position;
  colour_t    colour;
  logic       VGA_enable;

  modport master (output x_position, y_position, colour, VGA_enable);
  modport slave  (input  x_position, y_position, colour, VGA_enable);
endinterface

// File: rtl/frame_buffer.sv
// 320x240x6 simple dual-port RAM; registered read returns old data on a same-address write.
module frame_buffer
  import vga_pkg::*;
(
  input  logic     clock,
  input  logic     we_i,
  input  fb_addr_t waddr_i,
  input  colour_t  wdata_i,
  input  fb_addr_t raddr_i,
  output colour_t  rdata_o
);

  colour_t mem [FB_DEPTH];
  colour_t rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_display.sv
// Frame-buffer sink with 640x480 scanout (2x pixel doubling) and a vblank pacing pulse.
module vga_display
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT  = V_FRONT_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BACK   = V_BACK_DEF
) (
  input  logic         clock,
  input  logic         reset,
  vga_display_if.slave wr,
  output logic         frame_start,
  output logic         in_vblank,
  output logic [7:0]   VGA_R,
  output logic [7:0]   VGA_G,
  output logic [7:0]   VGA_B,
  output logic         VGA_HS,
  output logic         VGA_VS,
  output logic         VGA_BLANK_N,
  output logic         VGA_SYNC_N,
  output logic         VGA_CLK
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  localparam logic [HW-1:0] HLast      = HW'(HTotal - 1);
  localparam logic [HW-1:0] HActive    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HsStart    = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HsEnd      = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VLast      = VW'(VTotal - 1);
  localparam logic [VW-1:0] VActive    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VsStart    = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VsEnd      = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [VW-1:0] VFrameLine = VW'(V_ACTIVE - 1);

  logic          tick_q, tick_d;
  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    tick_d        = ~tick_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_start_d = 1'b0;
    if (tick_q) begin
      if (h_count_q == HLast) begin
        h_count_d     = '0;
        v_count_d     = (v_count_q == VLast) ? '0 : v_count_q + VW'(1);
        frame_start_d = (v_count_q == VFrameLine);
      end else begin
        h_count_d = h_count_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q        <= 1'b0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_start_q <= frame_start_d;
    end
  end

  sync_t      raw_sync;
  fb_addr_t   raw_addr;
  logic [8:0] fb_x;
  logic [7:0] fb_y;

  always_comb begin
    raw_sync.hs_n = ~((h_count_q >= HsStart) && (h_count_q <= HsEnd));
    raw_sync.vs_n = ~((v_count_q >= VsStart) && (v_count_q <= VsEnd));
    raw_sync.vis  = (h_count_q < HActive) && (v_count_q < VActive);
    fb_x          = 9'(h_count_q >> 1);
    fb_y          = 8'(v_count_q >> 1);
    // Keep the RAM index in range while blanked.
    raw_addr      = raw_sync.vis ? fb_addr(fb_x, fb_y) : '0;
  end

  logic     wr_en;
  fb_addr_t wr_addr;
  colour_t  rd_data;

  // Range check first so out-of-range coordinates cannot alias into a valid row.
  assign wr_en   = wr.VGA_enable && (wr.x_position < 9'(FB_WIDTH))
                   && (wr.y_position < 8'(FB_HEIGHT));
  assign wr_addr = fb_addr(wr.x_position, wr.y_position);

  sync_t      s1_sync_q, s2_sync_q;
  fb_addr_t   s1_addr_q;
  logic [7:0] r_q, g_q, b_q;

  frame_buffer u_fb (
    .clock   (clock),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr.colour),
    .raddr_i (s1_addr_q),
    .rdata_o (rd_data)
  );

  // RAM data for s1_addr_q lands on the off-tick clock, ready for the stage-2 capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_sync_q <= SyncIdle;
      s1_addr_q <= '0;
      s2_sync_q <= SyncIdle;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else if (tick_q) begin
      s1_sync_q <= raw_sync;
      s1_addr_q <= raw_addr;
      s2_sync_q <= s1_sync_q;
      r_q       <= s1_sync_q.vis ? expand2(rd_data[R_LSB +: 2]) : '0;
      g_q       <= s1_sync_q.vis ? expand2(rd_data[G_LSB +: 2]) : '0;
      b_q       <= s1_sync_q.vis ? expand2(rd_data[B_LSB +: 2]) : '0;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = s2_sync_q.hs_n;
  assign VGA_VS      = s2_sync_q.vs_n;
  assign VGA_BLANK_N = s2_sync_q.vis;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = tick_q;
  assign frame_start = frame_start_q;
  assign in_vblank   = (v_count_q >= VActive);

endmodule
